// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer index manager: buffer roles,
// index width, default address map and the registered index state.
package fb_pkg;

  // Width of a buffer index; enough for up to four buffers.
  localparam int IDX_W = 2;

  // Role encoding of a single frame buffer.
  localparam logic [1:0] ROLE_FREE    = 2'd0;
  localparam logic [1:0] ROLE_WRITING = 2'd1;
  localparam logic [1:0] ROLE_READY   = 2'd2;
  localparam logic [1:0] ROLE_READING = 2'd3;

  // Default DDR placement of the buffer ring.
  localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0004_0000;

  // Complete ownership state: who writes, who reads, and the optional
  // completed-but-unread frame. wr_valid=0 means the writer is stalled.
  typedef struct packed {
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic             rdy_valid;
    logic             wr_valid;
  } fb_state_t;

endpackage

// File: rtl/fb_edge_detect.sv
// Single-bit rising-edge detector. History resets to 1 so a level that is
// already high when reset releases is not mistaken for a new edge.
module fb_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;

  // Remember last cycle's input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/frame_buffer_manager.sv
// N-buffer (2..4) frame-buffer index manager. Tracks which DDR buffer the
// AXI writer fills and which one the reader scans out, swapping only at
// display frame start. All outputs are registered: an input edge seen in
// cycle n is reflected on the outputs in cycle n+1.
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter int                NUM_BUFS     = 3,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(DEF_FRAME_STRIDE),
  parameter bit                HOLD_MODE    = 1'b0,
  parameter int                CNT_W        = 16
) (
  input  logic              clk_100Mhz,
  input  logic              sys_rst_n,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic              wr_buf_valid,
  output logic              swap_pulse,
  output logic [CNT_W-1:0]  frames_written,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [CNT_W-1:0]  frames_repeat
);

  if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
    $error("frame_buffer_manager: NUM_BUFS must be in 2..4");
  end

  localparam fb_state_t RST_STATE = '{
    wr_idx:    '0,
    rd_idx:    IDX_W'(NUM_BUFS - 1),
    rdy_idx:   '0,
    rdy_valid: 1'b0,
    wr_valid:  1'b1
  };

  // Byte address of a buffer; wraps silently in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] idx_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * FRAME_STRIDE;
  endfunction

  // Lowest buffer index not in use by a, b, or (when c_v) c.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] pick_free(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic [IDX_W-1:0] c,
                                               input logic             c_v);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if ((IDX_W'(i) != a) && (IDX_W'(i) != b) && !(c_v && (IDX_W'(i) == c))) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  logic wr_ev;
  logic rd_ev;

  fb_edge_detect u_wr_edge (
    .clk   (clk_100Mhz),
    .rst_n (sys_rst_n),
    .din   (wr_frame_done),
    .rise  (wr_ev)
  );

  fb_edge_detect u_rd_edge (
    .clk   (clk_100Mhz),
    .rst_n (sys_rst_n),
    .din   (rd_frame_start),
    .rise  (rd_ev)
  );

  fb_state_t        st;
  fb_state_t        nx;
  logic             nx_swap;
  logic [CNT_W-1:0] nx_written;
  logic [CNT_W-1:0] nx_dropped;
  logic [CNT_W-1:0] nx_repeat;
  logic [IDX_W:0]   free_pick;

  // Next state: apply the writer completion first, then the reader frame
  // start on that result, so a simultaneous pair hands the fresh frame over.
  always_comb begin
    nx         = st;
    nx_swap    = 1'b0;
    nx_written = frames_written;
    nx_dropped = frames_dropped;
    nx_repeat  = frames_repeat;
    // The old READY buffer is excluded here: it is only a fallback (reclaim).
    free_pick  = pick_free(st.wr_idx, st.rd_idx, st.rdy_idx, st.rdy_valid);

    if (wr_ev) begin
      if (st.wr_valid) begin
        nx_written   = frames_written + CNT_W'(1);
        if (st.rdy_valid) begin
          nx_dropped = frames_dropped + CNT_W'(1);
        end
        nx.rdy_idx   = st.wr_idx;
        nx.rdy_valid = 1'b1;
        if (free_pick[IDX_W]) begin
          nx.wr_idx  = free_pick[IDX_W-1:0];
        end else if (!HOLD_MODE && st.rdy_valid) begin
          nx.wr_idx  = st.rdy_idx;
        end else begin
          nx.wr_valid = 1'b0;
        end
      end else begin
        nx_dropped = frames_dropped + CNT_W'(1);
      end
    end

    if (rd_ev) begin
      if (nx.rdy_valid) begin
        if (!nx.wr_valid) begin
          nx.wr_idx   = nx.rd_idx;
          nx.wr_valid = 1'b1;
        end
        nx.rd_idx    = nx.rdy_idx;
        nx.rdy_valid = 1'b0;
        nx_swap      = 1'b1;
      end else begin
        nx_repeat = frames_repeat + CNT_W'(1);
      end
    end
  end

  // Register bank: ownership state, pulse, counters and base addresses.
  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st             <= RST_STATE;
      swap_pulse     <= 1'b0;
      frames_written <= '0;
      frames_dropped <= '0;
      frames_repeat  <= '0;
      wr_base_addr   <= idx_addr(RST_STATE.wr_idx);
      rd_base_addr   <= idx_addr(RST_STATE.rd_idx);
    end else begin
      st             <= nx;
      swap_pulse     <= nx_swap;
      frames_written <= nx_written;
      frames_dropped <= nx_dropped;
      frames_repeat  <= nx_repeat;
      wr_base_addr   <= idx_addr(nx.wr_idx);
      rd_base_addr   <= idx_addr(nx.rd_idx);
    end
  end

  assign wr_buf_idx   = st.wr_idx;
  assign rd_buf_idx   = st.rd_idx;
  assign wr_buf_valid = st.wr_valid;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager: a 3-buffer overwrite instance
// and a 2-buffer hold instance share one clock and reset.
module tb_frame_buffer_manager;

  localparam logic [31:0] B  = 32'h1000_0000;
  localparam logic [31:0] S  = 32'h0004_0000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wr3 = 1'b0, rd3 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;

  logic [31:0] wr_base3, rd_base3, wr_base2, rd_base2;
  logic [1:0]  wr_idx3, rd_idx3, wr_idx2, rd_idx2;
  logic        wr_v3, swap3, wr_v2, swap2;
  logic [15:0] written3, dropped3, repeat3, written2, dropped2, repeat2;

  frame_buffer_manager #(.NUM_BUFS(3), .HOLD_MODE(1'b0)) dut3 (
    .clk_100Mhz     (clk),
    .sys_rst_n      (rst_n),
    .wr_frame_done  (wr3),
    .rd_frame_start (rd3),
    .wr_base_addr   (wr_base3),
    .rd_base_addr   (rd_base3),
    .wr_buf_idx     (wr_idx3),
    .rd_buf_idx     (rd_idx3),
    .wr_buf_valid   (wr_v3),
    .swap_pulse     (swap3),
    .frames_written (written3),
    .frames_dropped (dropped3),
    .frames_repeat  (repeat3)
  );

  frame_buffer_manager #(.NUM_BUFS(2), .HOLD_MODE(1'b1)) dut2 (
    .clk_100Mhz     (clk),
    .sys_rst_n      (rst_n),
    .wr_frame_done  (wr2),
    .rd_frame_start (rd2),
    .wr_base_addr   (wr_base2),
    .rd_base_addr   (rd_base2),
    .wr_buf_idx     (wr_idx2),
    .rd_buf_idx     (rd_idx2),
    .wr_buf_valid   (wr_v2),
    .swap_pulse     (swap2),
    .frames_written (written2),
    .frames_dropped (dropped2),
    .frames_repeat  (repeat2)
  );

  int tests  = 0;
  int failed = 0;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: mask bit0=wr3 bit1=rd3 bit2=wr2 bit3=rd2. Raise at a negedge,
  // drop at the next negedge; outputs then already show the update.
  task automatic pulse(input int mask);
    @(negedge clk);
    wr3 = mask[0]; rd3 = mask[1]; wr2 = mask[2]; rd2 = mask[3];
    @(negedge clk);
    wr3 = 1'b0; rd3 = 1'b0; wr2 = 1'b0; rd2 = 1'b0;
  endtask

  task automatic check_reset3(input string tag);
    check({tag, "_wr_idx3"}, 32'(wr_idx3), 32'd0);
    check({tag, "_rd_idx3"}, 32'(rd_idx3), 32'd2);
    check({tag, "_wr_base3"}, wr_base3, B);
    check({tag, "_rd_base3"}, rd_base3, B + 2 * S);
    check({tag, "_wr_v3"}, 32'(wr_v3), 32'd1);
    check({tag, "_swap3"}, 32'(swap3), 32'd0);
    check({tag, "_cnt3"}, 32'(written3) + 32'(dropped3) + 32'(repeat3), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_reset3("rst");
    check("rst_rd_idx2", 32'(rd_idx2), 32'd1);
    check("rst_rd_base2", rd_base2, B + S);
    check("rst_wr_v2", 32'(wr_v2), 32'd1);

    // Test 1: write then read on the 3-buffer instance
    pulse(1);
    check("t1_wr_idx", 32'(wr_idx3), 32'd1);
    check("t1_wr_base", wr_base3, B + S);
    check("t1_written", 32'(written3), 32'd1);
    check("t1_rd_idx_hold", 32'(rd_idx3), 32'd2);
    pulse(2);
    check("t1_rd_idx", 32'(rd_idx3), 32'd0);
    check("t1_swap_hi", 32'(swap3), 32'd1);
    check("t1_rd_base", rd_base3, B);
    @(negedge clk);
    check("t1_swap_lo", 32'(swap3), 32'd0);

    // Test 2: three completions without a read (overwrite policy)
    pulse(1);
    check("t2_wr_idx_a", 32'(wr_idx3), 32'd2);
    pulse(1);
    check("t2_wr_idx_b", 32'(wr_idx3), 32'd1);
    pulse(1);
    check("t2_written", 32'(written3), 32'd4);
    check("t2_dropped", 32'(dropped3), 32'd2);
    check("t2_wr_v", 32'(wr_v3), 32'd1);
    check("t2_wr_idx_c", 32'(wr_idx3), 32'd2);
    check("t2_wr_base", wr_base3, B + 2 * S);
    pulse(2);
    check("t2_rd_last", 32'(rd_idx3), 32'd1);
    check("t2_rd_base", rd_base3, B + S);
    check("t2_swap", 32'(swap3), 32'd1);

    // Test 5: five reads with nothing new
    for (int i = 0; i < 5; i++) begin
      pulse(2);
      check("t5_swap", 32'(swap3), 32'd0);
      check("t5_rd_idx", 32'(rd_idx3), 32'd1);
    end
    check("t5_repeat", 32'(repeat3), 32'd5);

    // Test 4: simultaneous write completion and frame start
    pulse(3);
    check("t4_rd_idx", 32'(rd_idx3), 32'd2);
    check("t4_wr_idx", 32'(wr_idx3), 32'd0);
    check("t4_swap", 32'(swap3), 32'd1);
    check("t4_repeat", 32'(repeat3), 32'd5);
    check("t4_written", 32'(written3), 32'd5);
    check("t4_dropped", 32'(dropped3), 32'd2);

    // Test 3: 2-buffer hold instance stalls and resumes
    pulse(4);
    check("t3_written", 32'(written2), 32'd1);
    check("t3_stall", 32'(wr_v2), 32'd0);
    pulse(4);
    check("t3_stall2", 32'(wr_v2), 32'd0);
    check("t3_dropped", 32'(dropped2), 32'd1);
    check("t3_written2", 32'(written2), 32'd1);
    pulse(8);
    check("t3_rd_idx", 32'(rd_idx2), 32'd0);
    check("t3_wr_idx", 32'(wr_idx2), 32'd1);
    check("t3_wr_v", 32'(wr_v2), 32'd1);
    check("t3_swap", 32'(swap2), 32'd1);
    check("t3_wr_base", wr_base2, B + S);
    check("t3_rd_base", rd_base2, B);

    // Test 6: asynchronous reset with inputs held high
    @(negedge clk);
    wr3 = 1'b1; rd3 = 1'b1; wr2 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset3("t6_async");
    check("t6_async_wr_v2", 32'(wr_v2), 32'd1);
    check("t6_async_cnt2", 32'(written2) + 32'(dropped2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset3("t6_rel");
    check("t6_rel_wr_idx2", 32'(wr_idx2), 32'd0);
    check("t6_rel_written2", 32'(written2), 32'd0);
    wr3 = 1'b0; rd3 = 1'b0; wr2 = 1'b0;
    @(negedge clk);
    pulse(2);
    check("t6_repeat_alive", 32'(repeat3), 32'd1);
    check("t6_rd_idx_alive", 32'(rd_idx3), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
